// File: rtl/alsu_pipe.sv
// Two-stage pipelined ALSU: stage 1 captures a qualified issue, stage 2 computes the
// result and maintains the invalid-operation LED blinker and saturating error counter.
module alsu_pipe #(
    parameter int  WIDTH          = 3,
    parameter      INPUT_PRIORITY = "A",
    parameter bit  FULL_ADDER     = 1'b1,
    parameter int  LED_W          = 16,
    parameter int  BLINK_DIV      = 4,
    localparam int OUT_W          = 2 * WIDTH,
    localparam int SH_W           = $clog2(OUT_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic [2:0]              opcode,
    input  logic                    cin,
    input  logic                    serial_in,
    input  logic                    red_op_A,
    input  logic                    red_op_B,
    input  logic                    bypass_A,
    input  logic                    bypass_B,
    input  logic                    direction,
    input  logic [SH_W-1:0]         shamt,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out,
    output logic [LED_W-1:0]        leds,
    output logic [7:0]              err_count
);

    localparam bit               PRI_B    = (INPUT_PRIORITY == "B");
    localparam int               DIV_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
    localparam int unsigned      OUT_WU   = OUT_W;

    typedef enum logic [2:0] {
        OP_OR     = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MULT   = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } op_e;

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_a, s1_b;
    op_e               s1_op;
    logic              s1_cin, s1_sin, s1_red_a, s1_red_b, s1_byp_a, s1_byp_b, s1_dir;
    logic [SH_W-1:0]   s1_shamt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_OR;
            s1_cin   <= 1'b0;
            s1_sin   <= 1'b0;
            s1_red_a <= 1'b0;
            s1_red_b <= 1'b0;
            s1_byp_a <= 1'b0;
            s1_byp_b <= 1'b0;
            s1_dir   <= 1'b0;
            s1_shamt <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a     <= A;
                s1_b     <= B;
                s1_op    <= op_e'(opcode);
                s1_cin   <= cin;
                s1_sin   <= serial_in;
                s1_red_a <= red_op_A;
                s1_red_b <= red_op_B;
                s1_byp_a <= bypass_A;
                s1_byp_b <= bypass_B;
                s1_dir   <= direction;
                s1_shamt <= shamt;
            end
        end
    end

    logic [OUT_W-1:0]   a_ext, b_ext, fill, res;
    logic [2*OUT_W-1:0] wide;
    logic               res_invalid, pick_b, red_src_b, red_bit;
    int unsigned        sh_amt, rot_amt;

    always_comb begin
        a_ext       = {{WIDTH{s1_a[WIDTH-1]}}, s1_a};
        b_ext       = {{WIDTH{s1_b[WIDTH-1]}}, s1_b};
        fill        = {OUT_W{s1_sin}};
        sh_amt      = 32'(s1_shamt);
        rot_amt     = sh_amt % OUT_WU;
        wide        = '0;
        res         = '0;
        res_invalid = 1'b0;
        pick_b      = (s1_byp_a && s1_byp_b) ? PRI_B : s1_byp_b;
        red_src_b   = (s1_red_a && s1_red_b) ? PRI_B : s1_red_b;
        red_bit     = 1'b0;

        if (s1_byp_a || s1_byp_b) begin
            res = pick_b ? b_ext : a_ext;
        end else if (s1_op == OP_RSV6 || s1_op == OP_RSV7 ||
                     ((s1_red_a || s1_red_b) && !(s1_op == OP_OR || s1_op == OP_XOR))) begin
            res_invalid = 1'b1;
        end else begin
            case (s1_op)
                OP_OR, OP_XOR: begin
                    if (s1_red_a || s1_red_b) begin
                        if (s1_op == OP_OR) red_bit = red_src_b ? |s1_b : |s1_a;
                        else                red_bit = red_src_b ? ^s1_b : ^s1_a;
                        res = {{(OUT_W-1){1'b0}}, red_bit};
                    end else begin
                        res = (s1_op == OP_OR) ? (a_ext | b_ext) : (a_ext ^ b_ext);
                    end
                end
                OP_ADD:  res = a_ext + b_ext + {{(OUT_W-1){1'b0}}, (FULL_ADDER & s1_cin)};
                OP_MULT: res = a_ext * b_ext;
                OP_SHIFT: begin
                    // shifting through a fill-padded double-width word makes vacated bits serial_in
                    if (sh_amt >= OUT_WU) begin
                        res = fill;
                    end else if (s1_dir) begin
                        wide = {out, fill} << sh_amt;
                        res  = wide[2*OUT_W-1:OUT_W];
                    end else begin
                        wide = {fill, out} >> sh_amt;
                        res  = wide[OUT_W-1:0];
                    end
                end
                OP_ROTATE: begin
                    if (s1_dir) begin
                        wide = {out, out} << rot_amt;
                        res  = wide[2*OUT_W-1:OUT_W];
                    end else begin
                        wide = {out, out} >> rot_amt;
                        res  = wide[OUT_W-1:0];
                    end
                end
                default: res = '0;
            endcase
        end
    end

    logic             blinking;
    logic [DIV_W-1:0] div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            leds      <= '0;
            err_count <= '0;
            blinking  <= 1'b0;
            div       <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out <= res;
                div <= '0;
                if (res_invalid) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    leds     <= '1;
                    blinking <= 1'b1;
                end else begin
                    leds     <= '0;
                    blinking <= 1'b0;
                end
            end else if (blinking) begin
                if (div == DIV_LAST) begin
                    div  <= '0;
                    leds <= ~leds;
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end

endmodule
